ifetch_queue: RTL and testbench

- Instruction fetch front end that produces the `inst` word consumed by the instruction decoder. It is the supplying end of the decoder's input interface.
- Keeps the fetch PC, issues one-word instruction reads to the memory controller, and buffers the returned words with their PCs in a circular queue.
- Presents queue-head words in order to the decode/dispatch stage.
- Discards everything on a control-flow redirect from commit (mispredict or jump).

---
 rtl/ifetch_queue_pkg.sv | 23 ++
 rtl/ifetch_queue_fifo.sv | 60 ++++++
 rtl/ifetch_queue.sv | 118 +++++++++++
 tb/tb_ifetch_queue.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_queue_pkg.sv
// Shared types for the instruction fetch queue: fetch FSM states and the
// {instruction, pc} entry stored in the circular buffer.
package ifetch_queue_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned INST_W = 32;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] pc;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return addr & ~ADDR_W'(3);
  endfunction

endpackage

// File: rtl/ifetch_queue_fifo.sv
// Circular buffer with push, pop, clear and a head read that returns zero when empty.
// Clear wins over push/pop; pop on an empty buffer is ignored.
module ifetch_queue_fifo #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 64
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_clear,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_wdata,
  output logic [DW-1:0] o_rdata,
  output logic [AW:0]   o_count,
  output logic          o_empty
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam int unsigned CW    = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign w_do_pop  = i_pop && (r_count != '0);
  // a full buffer can still accept a push when the head leaves in the same cycle
  assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (i_en) begin
      if (i_clear) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_do_push) r_tail <= r_tail + AW'(1);
        if (w_do_pop)  r_head <= r_head + AW'(1);
        if (w_do_push && !w_do_pop)      r_count <= r_count + CW'(1);
        else if (!w_do_push && w_do_pop) r_count <= r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_en && !i_rst && !i_clear && w_do_push) r_mem[r_tail] <= i_wdata;
  end

  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = o_empty ? '0 : r_mem[r_head];

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: one outstanding word read at a time, returned words
// queued with their PCs and presented in order to decode; a redirect discards all.
module ifetch_queue
  import ifetch_queue_pkg::*;
#(
  parameter int unsigned       QUEUE_SIZE_LOG = 4,
  parameter logic [ADDR_W-1:0] RESET_PC       = 32'h0
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_ack,
  input  logic [INST_W-1:0] mem_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] pc_out,
  input  logic              inst_pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] flush_pc
);

  localparam int unsigned CW    = QUEUE_SIZE_LOG + 1;
  localparam int unsigned DEPTH = 1 << QUEUE_SIZE_LOG;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [ADDR_W-1:0] r_req_addr;
  logic [ADDR_W-1:0] w_req_addr_nxt;
  logic              r_req_valid;
  logic              w_req_valid_nxt;
  logic              w_push;
  logic [CW-1:0]     w_count;
  logic              w_empty;
  fetch_entry_t      w_wentry;
  fetch_entry_t      w_head;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= FETCH_IDLE;
      r_pc        <= RESET_PC;
      r_req_addr  <= '0;
      r_req_valid <= 1'b0;
    end else if (rdy_in) begin
      r_state     <= w_state_nxt;
      r_pc        <= w_pc_nxt;
      r_req_addr  <= w_req_addr_nxt;
      r_req_valid <= w_req_valid_nxt;
    end
  end

  // Next-state: a flush overrides push and issue; an in-flight read becomes a drop.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_req_addr_nxt  = r_req_addr;
    w_req_valid_nxt = r_req_valid;
    w_push          = 1'b0;
    if (flush) begin
      w_pc_nxt        = word_align(flush_pc);
      w_req_valid_nxt = 1'b0;
      if (r_state != FETCH_IDLE) w_state_nxt = mem_ack ? FETCH_IDLE : FETCH_DROP;
    end else begin
      unique case (r_state)
        FETCH_IDLE: begin
          if (w_count < CW'(DEPTH)) begin
            w_state_nxt     = FETCH_WAIT;
            w_req_valid_nxt = 1'b1;
            w_req_addr_nxt  = r_pc;
          end
        end
        FETCH_WAIT: begin
          if (mem_ack) begin
            w_push          = 1'b1;
            w_pc_nxt        = r_pc + ADDR_W'(4);
            w_req_valid_nxt = 1'b0;
            w_state_nxt     = FETCH_IDLE;
          end
        end
        FETCH_DROP: begin
          if (mem_ack) w_state_nxt = FETCH_IDLE;
        end
        default: begin
          w_state_nxt     = FETCH_IDLE;
          w_req_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  assign w_wentry = '{inst: mem_data, pc: r_pc};

  ifetch_queue_fifo #(
    .AW (QUEUE_SIZE_LOG),
    .DW ($bits(fetch_entry_t))
  ) u_fifo (
    .i_clk   (clk_in),
    .i_rst   (rst_in),
    .i_en    (rdy_in),
    .i_clear (flush),
    .i_push  (w_push),
    .i_pop   (inst_pop),
    .i_wdata (w_wentry),
    .o_rdata (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  assign mem_req_valid = r_req_valid;
  assign mem_req_addr  = r_req_addr;
  assign inst_valid    = !w_empty;
  assign inst_out      = w_head.inst;
  assign pc_out        = w_head.pc;

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: directed scenarios plus a randomized run checked against
// a queue-level reference model that the bench acts as memory controller for.
module tb_ifetch_queue;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        rdy_in = 1'b1;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic        inst_valid;
  logic [31:0] inst_out;
  logic [31:0] pc_out;
  logic        inst_pop = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = '0;

  int checks   = 0;
  int failures = 0;

  // reference model: queued {inst, pc}, next fetch pc, request in flight, flushed read in flight
  logic [63:0] m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_req_addr;
  bit          m_busy;
  bit          m_drop;

  ifetch_queue #(.QUEUE_SIZE_LOG(4), .RESET_PC(32'h0)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .rdy_in        (rdy_in),
    .mem_req_valid (mem_req_valid),
    .mem_req_addr  (mem_req_addr),
    .mem_ack       (mem_ack),
    .mem_data      (mem_data),
    .inst_valid    (inst_valid),
    .inst_out      (inst_out),
    .pc_out        (pc_out),
    .inst_pop      (inst_pop),
    .flush         (flush),
    .flush_pc      (flush_pc)
  );

  always #5 clk_in = ~clk_in;

  // Drive one cycle of inputs, advance the model across the edge, settle 1 after it.
  task automatic tick(input logic rst, input logic rdy, input logic ack, input logic [31:0] data,
                      input logic pop, input logic fl, input logic [31:0] fpc);
    int n;
    rst_in = rst; rdy_in = rdy; mem_ack = ack; mem_data = data;
    inst_pop = pop; flush = fl; flush_pc = fpc;
    n = m_q.size();
    if (rst) begin
      m_q.delete(); m_pc = 32'h0; m_req_addr = 32'h0; m_busy = 0; m_drop = 0;
    end else if (rdy) begin
      if (fl) begin
        m_q.delete();
        m_pc   = {fpc[31:2], 2'b00};
        m_drop = (m_busy || m_drop) && !ack;
        m_busy = 0;
      end else begin
        if (pop && n > 0) void'(m_q.pop_front());
        if (m_busy && ack) begin
          m_q.push_back({data, m_pc});
          m_pc   = m_pc + 32'd4;
          m_busy = 0;
        end else if (m_drop && ack) begin
          m_drop = 0;
        end else if (!m_busy && !m_drop && n < 16) begin
          m_busy     = 1;
          m_req_addr = m_pc;
        end
      end
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    tick(0, 1, 0, 32'h0, 0, 0, 32'h0);
  endtask

  task automatic test_reset();
    tick(1, 1, 0, 32'h0, 0, 0, 32'h0);
    checks += 5;
    if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b want=0", mem_req_valid); end
    if (mem_req_addr !== 32'h0) begin failures++; $display("FAIL reset_req_addr got=%h want=0", mem_req_addr); end
    if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%b want=0", inst_valid); end
    if (inst_out !== 32'h0) begin failures++; $display("FAIL reset_inst_out got=%h want=0", inst_out); end
    if (pc_out !== 32'h0) begin failures++; $display("FAIL reset_pc_out got=%h want=0", pc_out); end
    idle();
    checks += 2;
    if (mem_req_valid !== 1'b1) begin failures++; $display("FAIL first_req_valid got=%b want=1", mem_req_valid); end
    if (mem_req_addr !== 32'h0) begin failures++; $display("FAIL first_req_addr got=%h want=0", mem_req_addr); end
    idle();
    idle();
    checks++;
    if (mem_req_valid !== 1'b1 || inst_valid !== 1'b0) begin
      failures++; $display("FAIL wait_hold req_valid=%b inst_valid=%b want 1/0", mem_req_valid, inst_valid);
    end
    tick(0, 1, 1, 32'h00500093, 0, 0, 32'h0);
    checks += 4;
    if (inst_valid !== 1'b1) begin failures++; $display("FAIL first_inst_valid got=%b want=1", inst_valid); end
    if (inst_out !== 32'h00500093) begin failures++; $display("FAIL first_inst_out got=%h want=00500093", inst_out); end
    if (pc_out !== 32'h0) begin failures++; $display("FAIL first_pc_out got=%h want=0", pc_out); end
    if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL gap_after_ack got=%b want=0", mem_req_valid); end
  endtask

  task automatic test_fill();
    int  n_acks = 0;
    bit  seen = 0;
    tick(1, 1, 0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 80; i++) begin
      if (mem_req_valid) n_acks++;
      tick(0, 1, mem_req_valid, 32'h1000_0000 + 32'(i), 0, 0, 32'h0);
    end
    checks += 4;
    if (n_acks != 16) begin failures++; $display("FAIL fill_accepted got=%0d want=16", n_acks); end
    if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL full_no_req got=%b want=0", mem_req_valid); end
    if (inst_valid !== 1'b1) begin failures++; $display("FAIL full_inst_valid got=%b want=1", inst_valid); end
    if (pc_out !== 32'h0) begin failures++; $display("FAIL full_head_pc got=%h want=0", pc_out); end
    tick(0, 1, 0, 32'h0, 1, 0, 32'h0);
    checks++;
    if (pc_out !== 32'h4) begin failures++; $display("FAIL pop_head_pc got=%h want=4", pc_out); end
    for (int i = 0; i < 4 && !seen; i++) begin
      idle();
      if (mem_req_valid) seen = 1;
    end
    checks++;
    if (!seen || mem_req_addr !== 32'h40) begin
      failures++; $display("FAIL refill_req seen=%0d addr=%h want addr=00000040", seen, mem_req_addr);
    end
  endtask

  task automatic test_flush_wait();
    bit found = 0;
    bit seen  = 0;
    tick(1, 1, 0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_req_valid && mem_req_addr == 32'h8) found = 1;
      else tick(0, 1, mem_req_valid, $urandom, 0, 0, 32'h0);
    end
    checks++;
    if (!found) begin failures++; $display("FAIL flush_reach_addr8 timed out"); end
    tick(0, 1, 0, 32'h0, 0, 1, 32'h1003);
    checks += 2;
    if (mem_req_valid !== 1'b0) begin failures++; $display("FAIL flush_req_drop got=%b want=0", mem_req_valid); end
    if (inst_valid !== 1'b0) begin failures++; $display("FAIL flush_inst_valid got=%b want=0", inst_valid); end
    tick(0, 1, 1, 32'hDEADBEEF, 0, 0, 32'h0);
    checks++;
    if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      failures++; $display("FAIL drop_ack inst_valid=%b req_valid=%b want 0/0", inst_valid, mem_req_valid);
    end
    for (int i = 0; i < 5 && !seen; i++) begin
      idle();
      if (mem_req_valid) seen = 1;
    end
    checks += 2;
    if (!seen || mem_req_addr !== 32'h1000) begin
      failures++; $display("FAIL redirect_req seen=%0d addr=%h want addr=00001000", seen, mem_req_addr);
    end
    if (inst_valid !== 1'b0) begin failures++; $display("FAIL redirect_empty got=%b want=0", inst_valid); end
    tick(0, 1, 1, 32'h12345678, 0, 0, 32'h0);
    checks += 2;
    if (inst_valid !== 1'b1 || inst_out !== 32'h12345678) begin
      failures++; $display("FAIL redirect_inst valid=%b inst=%h want 1/12345678", inst_valid, inst_out);
    end
    if (pc_out !== 32'h1000) begin failures++; $display("FAIL redirect_pc got=%h want=00001000", pc_out); end
  endtask

  task automatic test_flush_ack_pop();
    bit found = 0;
    tick(1, 1, 0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_q.size() == 3 && mem_req_valid) found = 1;
      else tick(0, 1, mem_req_valid, $urandom, 0, 0, 32'h0);
    end
    checks++;
    if (!found || inst_valid !== 1'b1) begin
      failures++; $display("FAIL fap_setup found=%0d inst_valid=%b want 1/1", found, inst_valid);
    end
    tick(0, 1, 1, 32'hBAD0BAD0, 1, 1, 32'h2000);
    checks++;
    if (inst_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      failures++; $display("FAIL fap_cleared inst_valid=%b req_valid=%b want 0/0", inst_valid, mem_req_valid);
    end
    idle();
    checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2000 || inst_valid !== 1'b0) begin
      failures++;
      $display("FAIL fap_next_req valid=%b addr=%h inst_valid=%b want 1/00002000/0", mem_req_valid, mem_req_addr, inst_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc = 32'h0;
    int          bad = 0;
    int          pops = 0;
    tick(1, 1, 0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 120; i++) begin
      if (inst_valid) begin
        if (pc_out !== exp_pc) bad++;
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
      tick(0, 1, mem_req_valid, $urandom, inst_valid, 0, 32'h0);
    end
    checks += 2;
    if (bad != 0) begin failures++; $display("FAIL stream_pc_sequence out_of_order=%0d want=0", bad); end
    if (pops < 30) begin failures++; $display("FAIL stream_rate pops=%0d want>=30", pops); end
  endtask

  task automatic test_rdy_stall();
    bit found = 0;
    int bad = 0;
    tick(1, 1, 0, 32'h0, 0, 0, 32'h0);
    idle();
    tick(0, 1, 1, 32'hA0A00001, 0, 0, 32'h0);
    for (int i = 0; i < 5 && !found; i++) begin
      if (mem_req_valid && mem_req_addr == 32'h4) found = 1;
      else idle();
    end
    checks++;
    if (!found) begin failures++; $display("FAIL stall_reach_addr4 timed out"); end
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 32'h0, 1, 1, 32'h3000);
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h4 || inst_valid !== 1'b1 ||
          inst_out !== 32'hA0A00001 || pc_out !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL stall_frozen changed_cycles=%0d want=0", bad); end
    tick(0, 1, 1, 32'hA0A00002, 0, 0, 32'h0);
    tick(0, 1, 0, 32'h0, 1, 0, 32'h0);
    checks++;
    if (inst_out !== 32'hA0A00002 || pc_out !== 32'h4) begin
      failures++; $display("FAIL stall_resume inst=%h pc=%h want a0a00002/00000004", inst_out, pc_out);
    end
  endtask

  task automatic test_random();
    logic [31:0] e_inst;
    logic [31:0] e_pc;
    tick(1, 1, 0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 600; i++) begin
      logic rdy;
      logic ack;
      rdy = ($urandom_range(9) != 0);
      ack = rdy && (m_busy || m_drop) && ($urandom_range(2) == 0);
      tick(0, rdy, ack, $urandom, $urandom_range(1) == 1, $urandom_range(29) == 0, $urandom);
      e_inst = (m_q.size() != 0) ? m_q[0][63:32] : 32'h0;
      e_pc   = (m_q.size() != 0) ? m_q[0][31:0] : 32'h0;
      checks += 4;
      if (mem_req_valid !== m_busy) begin
        failures++; $display("FAIL rnd_req_valid cyc=%0d got=%b want=%b", i, mem_req_valid, m_busy);
      end
      if (m_busy && mem_req_addr !== m_req_addr) begin
        failures++; $display("FAIL rnd_req_addr cyc=%0d got=%h want=%h", i, mem_req_addr, m_req_addr);
      end
      if (inst_valid !== (m_q.size() != 0)) begin
        failures++; $display("FAIL rnd_inst_valid cyc=%0d got=%b want=%b", i, inst_valid, m_q.size() != 0);
      end
      if (inst_out !== e_inst || pc_out !== e_pc) begin
        failures++; $display("FAIL rnd_head cyc=%0d got=%h/%h want=%h/%h", i, inst_out, pc_out, e_inst, e_pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_flush_wait();
    test_flush_ack_pop();
    test_back_to_back();
    test_rdy_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
